// File: rtl/instr_pkg.sv
// Shared ISA constants for the decoder and the ALU: opcodes, R-type
// function codes and the 4-bit ALU operation encoding.
package instr_pkg;

  // Primary opcodes, instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes, instruction[5:0]
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_LUI = 4'b1001;
  localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/instruction_decode_ctrl.sv
// Combinational opcode/funct -> control-signal table.
// Optional illegal-instruction flag: DECODE_ILLEGAL_FLAG_EN.
module instruction_decode_ctrl
  import instr_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
`ifdef DECODE_ILLEGAL_FLAG_EN
  output logic       illegal_s,
`endif
  output logic       regwrite_s,
  output logic       memwrite_s,
  output logic       memread_s,
  output logic [3:0] alu_op_s,
  output logic       imm_reg_s
);

  logic unknown_s;

  // Control table: safe defaults (no writes, ALU add) then per-opcode overrides
  always_comb begin
    regwrite_s = 1'b0;
    memwrite_s = 1'b0;
    memread_s  = 1'b0;
    alu_op_s   = ALU_ADD;
    imm_reg_s  = 1'b0;
    unknown_s  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        regwrite_s = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: alu_op_s = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op_s = ALU_SUB;
          FN_AND:          alu_op_s = ALU_AND;
          FN_OR:           alu_op_s = ALU_OR;
          FN_XOR:          alu_op_s = ALU_XOR;
          FN_NOR:          alu_op_s = ALU_NOR;
          FN_SLT:          alu_op_s = ALU_SLT;
          FN_SLL:          alu_op_s = ALU_SLL;
          FN_SRL:          alu_op_s = ALU_SRL;
          FN_SRA:          alu_op_s = ALU_SRA;
          default: begin
            // Unrecognised funct must not disturb the register file
            regwrite_s = 1'b0;
            alu_op_s   = ALU_ADD;
            unknown_s  = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        regwrite_s = 1'b1;
        imm_reg_s  = 1'b1;
        alu_op_s   = ALU_ADD;
      end
      OP_ANDI: begin
        regwrite_s = 1'b1;
        imm_reg_s  = 1'b1;
        alu_op_s   = ALU_AND;
      end
      OP_ORI: begin
        regwrite_s = 1'b1;
        imm_reg_s  = 1'b1;
        alu_op_s   = ALU_OR;
      end
      OP_XORI: begin
        regwrite_s = 1'b1;
        imm_reg_s  = 1'b1;
        alu_op_s   = ALU_XOR;
      end
      OP_SLTI: begin
        regwrite_s = 1'b1;
        imm_reg_s  = 1'b1;
        alu_op_s   = ALU_SLT;
      end
      OP_LUI: begin
        regwrite_s = 1'b1;
        imm_reg_s  = 1'b1;
        alu_op_s   = ALU_LUI;
      end
      OP_LW: begin
        regwrite_s = 1'b1;
        memread_s  = 1'b1;
        imm_reg_s  = 1'b1;
        alu_op_s   = ALU_ADD;
      end
      OP_SW: begin
        memwrite_s = 1'b1;
        imm_reg_s  = 1'b1;
        alu_op_s   = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        // Branch compares by subtraction, nothing is written
        alu_op_s = ALU_SUB;
      end
      OP_J: begin
        alu_op_s = ALU_ADD;
      end
      default: begin
        unknown_s = 1'b1;
      end
    endcase
  end

`ifdef DECODE_ILLEGAL_FLAG_EN
  assign illegal_s = unknown_s;
`else
  // Without the flag port the unknown indication has no consumer
  logic unused_s;
  assign unused_s = unknown_s;
`endif

endmodule

// File: rtl/instruction_decode.sv
// MIPS-style instruction decoder with registered outputs (fetch-to-decode
// pipeline register). Optional illegal output: DECODE_ILLEGAL_FLAG_EN.
module instruction_decode
  import instr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  output logic [5:0]  opcode,
  output logic [25:0] adr,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm,
  output logic        regwrite,
  output logic        memwrite,
  output logic        memread,
  output logic [3:0]  aluOp,
`ifdef DECODE_ILLEGAL_FLAG_EN
  output logic        illegal,
`endif
  output logic        immReg
);

  logic       regwrite_s;
  logic       memwrite_s;
  logic       memread_s;
  logic [3:0] alu_op_s;
  logic       imm_reg_s;
  logic [4:0] rd_s;
`ifdef DECODE_ILLEGAL_FLAG_EN
  logic       illegal_s;
`endif

  instruction_decode_ctrl u_ctrl (
    .opcode     (instruction[31:26]),
    .funct      (instruction[5:0]),
`ifdef DECODE_ILLEGAL_FLAG_EN
    .illegal_s  (illegal_s),
`endif
    .regwrite_s (regwrite_s),
    .memwrite_s (memwrite_s),
    .memread_s  (memread_s),
    .alu_op_s   (alu_op_s),
    .imm_reg_s  (imm_reg_s)
  );

  // Destination register: rd field for R-type, rt field for everything else
  always_comb begin
    rd_s = instruction[20:16];
    if (instruction[31:26] == OP_RTYPE) begin
      rd_s = instruction[15:11];
    end else begin
      rd_s = instruction[20:16];
    end
  end

  // Output register: clears on synchronous active-low reset, else captures decode
  always_ff @(posedge clk) begin
    if (!rst) begin
      opcode   <= 6'd0;
      adr      <= 26'd0;
      rs       <= 5'd0;
      rt       <= 5'd0;
      rd       <= 5'd0;
      shamt    <= 5'd0;
      funct    <= 6'd0;
      imm      <= 16'd0;
      regwrite <= 1'b0;
      memwrite <= 1'b0;
      memread  <= 1'b0;
      aluOp    <= 4'd0;
      immReg   <= 1'b0;
`ifdef DECODE_ILLEGAL_FLAG_EN
      illegal  <= 1'b0;
`endif
    end else begin
      opcode   <= instruction[31:26];
      adr      <= instruction[25:0];
      rs       <= instruction[25:21];
      rt       <= instruction[20:16];
      rd       <= rd_s;
      shamt    <= instruction[10:6];
      funct    <= instruction[5:0];
      imm      <= instruction[15:0];
      regwrite <= regwrite_s;
      memwrite <= memwrite_s;
      memread  <= memread_s;
      aluOp    <= alu_op_s;
      immReg   <= imm_reg_s;
`ifdef DECODE_ILLEGAL_FLAG_EN
      illegal  <= illegal_s;
`endif
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed self-checking bench for instruction_decode.
// Checks the illegal flag as well when DECODE_ILLEGAL_FLAG_EN is defined.
module tb_instruction_decode;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [5:0]  opcode;
  logic [25:0] adr;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        regwrite;
  logic        memwrite;
  logic        memread;
  logic [3:0]  aluOp;
  logic        immReg;
`ifdef DECODE_ILLEGAL_FLAG_EN
  logic        illegal;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  instruction_decode dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .opcode      (opcode),
    .adr         (adr),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .funct       (funct),
    .imm         (imm),
    .regwrite    (regwrite),
    .memwrite    (memwrite),
    .memread     (memread),
    .aluOp       (aluOp),
`ifdef DECODE_ILLEGAL_FLAG_EN
    .illegal     (illegal),
`endif
    .immReg      (immReg)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic rw, input logic mw,
                            input logic mr, input logic [3:0] op, input logic ir);
    check({tag, ".regwrite"}, {31'd0, regwrite}, {31'd0, rw});
    check({tag, ".memwrite"}, {31'd0, memwrite}, {31'd0, mw});
    check({tag, ".memread"},  {31'd0, memread},  {31'd0, mr});
    check({tag, ".aluOp"},    {28'd0, aluOp},    {28'd0, op});
    check({tag, ".immReg"},   {31'd0, immReg},   {31'd0, ir});
  endtask

  task automatic check_ill(input string tag, input logic exp_ill);
`ifdef DECODE_ILLEGAL_FLAG_EN
    check({tag, ".illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
`else
    if (exp_ill === 1'bx) $display("note: unused illegal expectation for %s", tag);
`endif
  endtask

  // Drive at negedge, let one rising edge pass, sample 1 ns after it
  task automatic issue(input logic [31:0] instr);
    @(negedge clk);
    instruction = instr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b0;
    instruction = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    // Reset clears everything despite an all-ones instruction
    check("rst.opcode", {26'd0, opcode}, 32'd0);
    check("rst.adr",    {6'd0, adr},     32'd0);
    check("rst.rs",     {27'd0, rs},     32'd0);
    check("rst.rt",     {27'd0, rt},     32'd0);
    check("rst.rd",     {27'd0, rd},     32'd0);
    check("rst.shamt",  {27'd0, shamt},  32'd0);
    check("rst.funct",  {26'd0, funct},  32'd0);
    check("rst.imm",    {16'd0, imm},    32'd0);
    check_ctrl("rst", 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    check_ill("rst", 1'b0);

    // R-type SUB
    @(negedge clk);
    rst = 1'b1;
    instruction = 32'h000A_5B22;
    @(posedge clk);
    #1;
    check("sub.opcode", {26'd0, opcode}, 32'd0);
    check("sub.rs",     {27'd0, rs},     32'd0);
    check("sub.rt",     {27'd0, rt},     32'd10);
    check("sub.rd",     {27'd0, rd},     32'd11);
    check("sub.shamt",  {27'd0, shamt},  32'd12);
    check("sub.funct",  {26'd0, funct},  32'h22);
    check("sub.imm",    {16'd0, imm},    32'h5B22);
    check("sub.adr",    {6'd0, adr},     32'h00A_5B22);
    check_ctrl("sub", 1'b1, 1'b0, 1'b0, 4'b0110, 1'b0);
    check_ill("sub", 1'b0);

    // lw $10,16($2)
    issue(32'h8C4A_0010);
    check("lw.opcode", {26'd0, opcode}, 32'h23);
    check("lw.rs",     {27'd0, rs},     32'd2);
    check("lw.rt",     {27'd0, rt},     32'd10);
    check("lw.rd",     {27'd0, rd},     32'd10);
    check("lw.imm",    {16'd0, imm},    32'h0010);
    check_ctrl("lw", 1'b1, 1'b0, 1'b1, 4'b0010, 1'b1);

    // sw
    issue(32'hAC4A_0010);
    check_ctrl("sw", 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1);
    check_ill("sw", 1'b0);

    // addi then beq back-to-back, with a latency check in between
    issue(32'h2149_FFFF);
    check("addi.rd",  {27'd0, rd},  32'd9);
    check("addi.imm", {16'd0, imm}, 32'hFFFF);
    check_ctrl("addi", 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1);
    @(negedge clk);
    instruction = 32'h112A_0003;
    #1;
    check("lat.hold_imm", {16'd0, imm}, 32'hFFFF);
    check("lat.hold_rw",  {31'd0, regwrite}, 32'd1);
    @(posedge clk);
    #1;
    check("beq.rd",  {27'd0, rd},  32'd10);
    check("beq.imm", {16'd0, imm}, 32'h0003);
    check_ctrl("beq", 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0);

    // Unknown opcode
    issue(32'hFC00_0000);
    check("unk.opcode", {26'd0, opcode}, 32'h3F);
    check_ctrl("unk", 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
    check_ill("unk", 1'b1);

    // NOP: all-zero word decodes as SLL to $0
    issue(32'h0000_0000);
    check("nop.rd", {27'd0, rd}, 32'd0);
    check_ctrl("nop", 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0);
    check_ill("nop", 1'b0);

    // R-type with unknown funct 0x01
    issue(32'h0000_0001);
    check_ctrl("badfn", 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
    check_ill("badfn", 1'b1);

    // lui $1,0x1234
    issue(32'h3C01_1234);
    check("lui.rd", {27'd0, rd}, 32'd1);
    check_ctrl("lui", 1'b1, 1'b0, 1'b0, 4'b1001, 1'b1);

    // R-type NOR: rs=1 rt=2 rd=3
    issue(32'h0022_1827);
    check("nor.rd", {27'd0, rd}, 32'd3);
    check_ctrl("nor", 1'b1, 1'b0, 1'b0, 4'b1100, 1'b0);

    // R-type SRA: rt=2 rd=3 shamt=4
    issue(32'h0002_1903);
    check("sra.shamt", {27'd0, shamt}, 32'd4);
    check_ctrl("sra", 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0);

    // j 0x10
    issue(32'h0800_0010);
    check("j.adr", {6'd0, adr}, 32'h10);
    check_ctrl("j", 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
    check_ill("j", 1'b0);

    // ori / slti
    issue(32'h3422_00FF);
    check_ctrl("ori", 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1);
    issue(32'h2822_0005);
    check_ctrl("slti", 1'b1, 1'b0, 1'b0, 4'b0111, 1'b1);

    // Reset mid-stream clears a live decode
    @(negedge clk);
    rst = 1'b0;
    instruction = 32'h8C4A_0010;
    @(posedge clk);
    #1;
    check("rst2.rt",  {27'd0, rt},  32'd0);
    check("rst2.imm", {16'd0, imm}, 32'd0);
    check_ctrl("rst2", 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
